// File: rtl/op_sram_arbiter.sv
// Cycle-by-cycle arbiter sharing the single-port OP SRAM between the host loader
// and the corelet: strict host priority or fair round-robin with a burst limit.
module op_sram_arbiter #(
    parameter int DW        = 128,
    parameter int AW        = 4,
    parameter int MAX_BURST = 4,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          host_sel,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_gnt,
    output logic          h_rvalid,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] rdata,
    output logic          sram_cen,
    output logic          sram_wen,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_d,
    input  logic [DW-1:0] sram_q,
    output logic [CW-1:0] conflict_cnt
);

    localparam int BCW = $clog2(MAX_BURST + 1);
    localparam logic [BCW-1:0] BC_MAX = BCW'(MAX_BURST);

    logic           r_last;
    logic [BCW-1:0] r_bc;
    logic           r_h_rv;
    logic           r_c_rv;
    logic [CW-1:0]  r_cnt;

    logic w_h_gnt;
    logic w_c_gnt;
    logic w_any_gnt;

    // Under contention both the alternation rule (bc below the cap) and the
    // burst cap (bc at MAX_BURST) hand the grant to whoever is not last.
    always_comb begin
        w_h_gnt = 1'b0;
        w_c_gnt = 1'b0;
        if (!reset) begin
            if (host_sel) begin
                w_h_gnt = h_req;
                w_c_gnt = c_req && !h_req;
            end else if (h_req && c_req) begin
                if (r_bc < BC_MAX) begin
                    w_h_gnt = r_last;
                    w_c_gnt = !r_last;
                end else begin
                    w_h_gnt = r_last;
                    w_c_gnt = !r_last;
                end
            end else begin
                w_h_gnt = h_req;
                w_c_gnt = c_req;
            end
        end
    end

    assign w_any_gnt = w_h_gnt || w_c_gnt;

    always_comb begin
        sram_cen = 1'b1;
        sram_wen = 1'b1;
        sram_a   = '0;
        sram_d   = '0;
        if (w_h_gnt) begin
            sram_cen = 1'b0;
            sram_wen = !h_we;
            sram_a   = h_addr;
            sram_d   = h_wdata;
        end else if (w_c_gnt) begin
            sram_cen = 1'b0;
            sram_wen = !c_we;
            sram_a   = c_addr;
            sram_d   = c_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= 1'b1;
            r_bc   <= '0;
            r_h_rv <= 1'b0;
            r_c_rv <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_h_rv <= w_h_gnt && !h_we;
            r_c_rv <= w_c_gnt && !c_we;
            if (!w_any_gnt) begin
                r_bc <= '0;
            end else if (w_c_gnt == r_last) begin
                if (r_bc != BC_MAX) begin
                    r_bc <= r_bc + BCW'(1);
                end
            end else begin
                r_bc   <= BCW'(1);
                r_last <= w_c_gnt;
            end
            if (h_req && c_req && (r_cnt != {CW{1'b1}})) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // A read granted just before reset must not surface while reset is high.
    assign h_rvalid     = r_h_rv && !reset;
    assign c_rvalid     = r_c_rv && !reset;
    assign h_gnt        = w_h_gnt;
    assign c_gnt        = w_c_gnt;
    assign rdata        = sram_q;
    assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_op_sram_arbiter.sv
// Self-checking bench for op_sram_arbiter: SRAM model, read-data scoreboard and
// one task per scenario.
module tb_op_sram_arbiter;

    localparam int DW = 128;
    localparam int AW = 4;
    localparam int MB = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          host_sel;
    logic          h_req, h_we, c_req, c_we;
    logic [AW-1:0] h_addr, c_addr;
    logic [DW-1:0] h_wdata, c_wdata;
    logic          h_gnt, h_rvalid, c_gnt, c_rvalid;
    logic [DW-1:0] rdata;
    logic          sram_cen, sram_wen;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;
    logic [CW-1:0] conflict_cnt;

    typedef struct packed {
        logic          owner;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] sramMem [16];
    logic [DW-1:0] refMem  [16];
    int            checks = 0;
    int            errors = 0;

    op_sram_arbiter #(.DW(DW), .AW(AW), .MAX_BURST(MB), .CW(CW)) dut (
        .clk(clk), .reset(reset), .host_sel(host_sel),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid),
        .rdata(rdata), .sram_cen(sram_cen), .sram_wen(sram_wen),
        .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural single-port SRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) sramMem[sram_a] <= sram_d;
            else           sram_q <= sramMem[sram_a];
        end
    end

    // Scoreboard: every rvalid must match the oldest outstanding expected read.
    always @(negedge clk) begin
        exp_t e;
        if (h_rvalid && c_rvalid) begin
            checks++; errors++;
            $display("[TB] FAIL both_rvalid: h_rvalid=1 c_rvalid=1, required at most one");
        end else if (h_rvalid || c_rvalid) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_rvalid: h=%0b c=%0b with nothing outstanding", h_rvalid, c_rvalid);
            end else begin
                e = sbq.pop_front();
                if (c_rvalid !== e.owner || rdata !== e.data) begin
                    errors++;
                    $display("[TB] FAIL read_data: owner=%0b rdata=%h, required owner=%0b rdata=%h",
                             c_rvalid, rdata, e.owner, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        setIdle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drainIdle();
        setIdle();
        @(negedge clk);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        host_sel = 1'b1;
        setIdle();
        h_req = 1; c_req = 1;
        tick();
        @(negedge clk);
        checks++;
        if (h_gnt !== 0 || c_gnt !== 0 || sram_cen !== 1 || sram_wen !== 1 || conflict_cnt !== 0) begin
            errors++;
            $display("[TB] FAIL reset_state: h_gnt=%0b c_gnt=%0b cen=%0b wen=%0b cnt=%0d, required 0 0 1 1 0",
                     h_gnt, c_gnt, sram_cen, sram_wen, conflict_cnt);
        end
        tick();
        reset = 1'b0;
        drainIdle();
    endtask

    task automatic test_host_write_read();
        host_sel = 1'b1;
        for (int i = 0; i < 16; i++) begin
            h_req = 1; h_we = 1; h_addr = AW'(i);
            h_wdata = {4{32'hC0DE_0000 + 32'(i)}};
            refMem[i] = h_wdata;
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (h_gnt !== 1 || sram_cen !== 0 || sram_wen !== 0 || sram_a !== 0 || sram_d !== h_wdata) begin
                    errors++;
                    $display("[TB] FAIL preload_cmd: gnt=%0b cen=%0b wen=%0b a=%0d", h_gnt, sram_cen, sram_wen, sram_a);
                end
            end
            tick();
        end
        h_req = 1; h_we = 1; h_addr = 3; h_wdata = {16{8'hA5}};
        refMem[3] = h_wdata;
        @(negedge clk);
        checks++;
        if (h_gnt !== 1 || c_gnt !== 0 || sram_cen !== 0 || sram_wen !== 0 || sram_a !== 3) begin
            errors++;
            $display("[TB] FAIL host_write: gnt=%0b cgnt=%0b cen=%0b wen=%0b a=%0d, required 1 0 0 0 3",
                     h_gnt, c_gnt, sram_cen, sram_wen, sram_a);
        end
        tick();
        h_we = 0; h_wdata = '0;
        @(negedge clk);
        checks++;
        if (h_gnt !== 1 || sram_cen !== 0 || sram_wen !== 1 || sram_a !== 3) begin
            errors++;
            $display("[TB] FAIL host_read_cmd: gnt=%0b cen=%0b wen=%0b a=%0d, required 1 0 1 3",
                     h_gnt, sram_cen, sram_wen, sram_a);
        end
        sbq.push_back('{owner: 1'b0, data: {16{8'hA5}}});
        tick();
        setIdle();
        @(negedge clk);
        checks++;
        if (h_rvalid !== 1 || c_rvalid !== 0 || sram_cen !== 1) begin
            errors++;
            $display("[TB] FAIL host_rvalid: h_rvalid=%0b c_rvalid=%0b cen=%0b, required 1 0 1",
                     h_rvalid, c_rvalid, sram_cen);
        end
        tick();
    endtask

    task automatic test_strict_priority();
        doReset();
        host_sel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            h_req = 1; h_addr = 1; c_req = 1; c_addr = 2;
            @(negedge clk);
            checks++;
            if (h_gnt !== 1 || c_gnt !== 0) begin
                errors++;
                $display("[TB] FAIL strict_gnt[%0d]: h=%0b c=%0b, required 1 0", i, h_gnt, c_gnt);
            end
            sbq.push_back('{owner: 1'b0, data: refMem[1]});
            tick();
        end
        h_req = 0;
        @(negedge clk);
        checks++;
        if (h_gnt !== 0 || c_gnt !== 1) begin
            errors++;
            $display("[TB] FAIL strict_release: h=%0b c=%0b, required 0 1", h_gnt, c_gnt);
        end
        sbq.push_back('{owner: 1'b1, data: refMem[2]});
        tick();
        setIdle();
        @(negedge clk);
        checks++;
        if (conflict_cnt !== 5) begin
            errors++;
            $display("[TB] FAIL strict_conflict_cnt: got %0d, required 5", conflict_cnt);
        end
        tick();
    endtask

    task automatic test_fair_alternation();
        doReset();
        host_sel = 1'b0;
        for (int i = 0; i < 6; i++) begin
            h_req = 1; h_addr = 4; c_req = 1; c_addr = 5;
            @(negedge clk);
            checks++;
            if (h_gnt !== ((i % 2) == 0) || c_gnt !== ((i % 2) == 1)) begin
                errors++;
                $display("[TB] FAIL fair_gnt[%0d]: h=%0b c=%0b, required %0b %0b",
                         i, h_gnt, c_gnt, (i % 2) == 0, (i % 2) == 1);
            end
            if ((i % 2) == 0) sbq.push_back('{owner: 1'b0, data: refMem[4]});
            else              sbq.push_back('{owner: 1'b1, data: refMem[5]});
            tick();
        end
        drainIdle();
    endtask

    task automatic test_burst_limit();
        doReset();
        host_sel = 1'b0;
        for (int i = 0; i < 6; i++) begin
            c_req = 1; c_addr = 6;
            @(negedge clk);
            checks++;
            if (c_gnt !== 1 || h_gnt !== 0) begin
                errors++;
                $display("[TB] FAIL burst_solo[%0d]: h=%0b c=%0b, required 0 1", i, h_gnt, c_gnt);
            end
            sbq.push_back('{owner: 1'b1, data: refMem[6]});
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            h_req = 1; h_addr = 7; c_req = 1; c_addr = 6;
            @(negedge clk);
            checks++;
            if (h_gnt !== ((i % 2) == 0) || c_gnt !== ((i % 2) == 1)) begin
                errors++;
                $display("[TB] FAIL burst_contend[%0d]: h=%0b c=%0b, required %0b %0b",
                         i, h_gnt, c_gnt, (i % 2) == 0, (i % 2) == 1);
            end
            if ((i % 2) == 0) sbq.push_back('{owner: 1'b0, data: refMem[7]});
            else              sbq.push_back('{owner: 1'b1, data: refMem[6]});
            tick();
        end
        drainIdle();
    endtask

    task automatic test_reset_mid_read();
        doReset();
        host_sel = 1'b0;
        h_req = 1; h_addr = 8;
        @(negedge clk);
        checks++;
        if (h_gnt !== 1) begin
            errors++;
            $display("[TB] FAIL midread_grant: h_gnt=%0b, required 1", h_gnt);
        end
        tick();
        reset = 1'b1;
        c_req = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (h_rvalid !== 0 || h_gnt !== 0 || c_gnt !== 0 || sram_cen !== 1) begin
                errors++;
                $display("[TB] FAIL midread_reset[%0d]: rvalid=%0b h=%0b c=%0b cen=%0b, required 0 0 0 1",
                         i, h_rvalid, h_gnt, c_gnt, sram_cen);
            end
            tick();
        end
        reset = 1'b0;
        h_addr = 9; c_addr = 10;
        @(negedge clk);
        checks++;
        if (conflict_cnt !== 0 || h_gnt !== 1 || c_gnt !== 0) begin
            errors++;
            $display("[TB] FAIL midread_after: cnt=%0d h=%0b c=%0b, required 0 1 0", conflict_cnt, h_gnt, c_gnt);
        end
        sbq.push_back('{owner: 1'b0, data: refMem[9]});
        tick();
        drainIdle();
    endtask

    task automatic test_saturation();
        doReset();
        host_sel = 1'b1;
        for (int i = 0; i < 20; i++) begin
            h_req = 1; h_we = 1; h_addr = 11; h_wdata = {4{32'(i)}};
            refMem[11] = h_wdata;
            c_req = 1; c_we = 1; c_addr = 12; c_wdata = '1;
            @(negedge clk);
            if (i == 14 || i == 15) begin
                checks++;
                if (conflict_cnt !== CW'(i)) begin
                    errors++;
                    $display("[TB] FAIL sat_count[%0d]: got %0d, required %0d", i, conflict_cnt, i);
                end
            end
            tick();
        end
        setIdle();
        @(negedge clk);
        checks++;
        if (conflict_cnt !== 15) begin
            errors++;
            $display("[TB] FAIL sat_hold: got %0d, required 15", conflict_cnt);
        end
        tick();
        h_req = 1; h_addr = 11;
        @(negedge clk);
        sbq.push_back('{owner: 1'b0, data: refMem[11]});
        tick();
        drainIdle();
    endtask

    initial begin
        reset = 1'b1;
        host_sel = 1'b1;
        setIdle();
        test_reset();
        test_host_write_read();
        test_strict_priority();
        test_fair_alternation();
        test_burst_limit();
        test_reset_mid_read();
        test_saturation();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL outstanding_reads: %0d left, required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/op_sram_arbiter.md
Name: op_sram_arbiter

Overview:
- Shares the single-port OP SRAM (16x128) between two requesters: the host/testbench loader port (h_*) and the corelet port (c_*).
- Replaces the static select mux in front of the SRAM with a cycle-by-cycle arbiter that supports two policies:
  - strict host priority when host_sel=1;
  - round-robin with a burst limit when host_sel=0.
- Returns read data and a per-requester read-valid, and counts contention cycles.

Parameters:
- DW, 128, SRAM data width.
- AW, 4, SRAM address width.
- MAX_BURST, 4, maximum consecutive grants to one requester while the other is requesting (fair mode only), >=1.
- CW, 16, width of the contention counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- host_sel  input  1  1 = host strict priority; 0 = fair round-robin with burst limit.
- h_req  input  1  host access request.
- h_we  input  1  host write (1) / read (0).
- h_addr  input  AW  host address.
- h_wdata  input  DW  host write data.
- h_gnt  output  1  host request accepted this cycle.
- h_rvalid  output  1  rdata holds the host's read result.
- c_req, c_we, c_addr, c_wdata  input  1/1/AW/DW  corelet request, same meaning as the host fields.
- c_gnt  output  1  corelet request accepted this cycle.
- c_rvalid  output  1  rdata holds the corelet's read result.
- rdata  output  DW  SRAM Q forwarded to both requesters; qualify with *_rvalid.
- sram_cen  output  1  SRAM chip enable, active-low.
- sram_wen  output  1  SRAM write enable, active-low.
- sram_a  output  AW  SRAM address.
- sram_d  output  DW  SRAM write data.
- sram_q  input  DW  SRAM read data, valid one cycle after a read command.
- conflict_cnt  output  CW  saturating count of cycles with h_req && c_req.

Behaviour:
- Grants are combinational from req, host_sel and the arbiter state. At most one of h_gnt/c_gnt is high in any cycle. A request is consumed in the cycle its gnt is high.
- The SRAM command is driven in the grant cycle:
  - sram_cen=0;
  - sram_wen = !we of the granted requester;
  - sram_a and sram_d taken from the granted requester.
  - With no grant: sram_cen=1, sram_wen=1, sram_a=0, sram_d=0.
- Read latency is 1 cycle. A granted read in cycle N gives owner_rvalid=1 in cycle N+1 (registered) with rdata=sram_q. Granted writes produce no rvalid.
- rvalid registers are cleared whenever no read was granted in the previous cycle. Back-to-back reads give back-to-back rvalids, alternating owners if grants alternate.
- State registers:
  - last (0=host, 1=corelet), holding the most recent grantee;
  - burst counter bc, 0..MAX_BURST, counting consecutive grants to last;
  - h_rv_q and c_rv_q;
  - conflict_cnt.
- host_sel=1 policy: h_req wins always; c_gnt = c_req && !h_req. bc and last still update as in fair mode.
- host_sel=0 policy, only one requester active: that requester is granted.
- host_sel=0 policy, both active:
  - if bc < MAX_BURST, grant the requester that is NOT last (alternate);
  - if alternation is blocked because the other did not request earlier, the burst rule applies next: when bc == MAX_BURST, grant the other requester.
  - Net effect: under continuous dual requests the grants alternate 1:1, and a requester that was alone never holds more than MAX_BURST grants once contention starts.
- bc update:
  - grant to the same owner as last: bc = min(bc+1, MAX_BURST);
  - grant to the other owner: bc=1 and last flips;
  - no grant: bc=0 and last holds.
- conflict_cnt increments every cycle h_req && c_req, saturating at all-ones (no wrap).
- host_sel may change on any cycle. It takes effect in the same cycle's arbitration, and a pending rvalid is unaffected.
- Reset:
  - all registers clear: last=1, so the host wins the first fair contention; bc=0; rvalids=0; conflict_cnt=0.
  - While reset=1, both gnts are forced to 0, sram_cen=1 and sram_wen=1.
  - A read granted in the cycle before reset asserts produces no rvalid. rdata always follows sram_q.
- Address range: addresses are passed unchecked; the SRAM holds 16 entries, so AW=4 covers all of them.

Test Plan:
- Host-only write then read: h_req=1, h_we=1, h_addr=3, h_wdata=128'hA5…A5, then a read of addr 3 → h_gnt=1 both cycles, sram_cen=0/sram_wen=0 then 1; h_rvalid=1 one cycle after the read with rdata=A5…A5; c_rvalid stays 0.
- Strict priority: host_sel=1, h_req and c_req held high for 5 cycles → h_gnt=1 all 5, c_gnt=0; c_gnt=1 in the first cycle h_req drops; conflict_cnt=5.
- Fair alternation: host_sel=0, both requesting reads to distinct addresses for 6 cycles after reset → grants H,C,H,C,H,C; rvalids alternate h,c… one cycle later, each paired with the matching stored data.
- Burst limit: MAX_BURST=4, corelet requests alone for 6 cycles, then the host joins → c_gnt for the 6 solo cycles, then the host is granted on the first contention cycle and grants alternate afterwards.
- Reset mid-read: host read granted in cycle N, reset=1 in cycle N+1 → h_rvalid=0 in N+1 and N+2, gnts=0, sram_cen=1; after reset deasserts, conflict_cnt=0 and the first dual request goes to the host.
- Saturation: CW=4, both requesting for 20 cycles → conflict_cnt reaches 15 and holds at 15.
